// File: rtl/power_check_pkg.sv
// Shared types and constants for the power-test counter checker tile.
package power_check_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_e;

  localparam logic [1:0] SEL_ERR_LO = 2'b00;
  localparam logic [1:0] SEL_ERR_HI = 2'b01;
  localparam logic [1:0] SEL_BAD    = 2'b10;
  localparam logic [1:0] SEL_LOSS   = 2'b11;

  localparam int ERR_W  = 16;
  localparam int LOSS_W = 8;
  localparam int HB_W   = 24;

  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/power_check_if.sv
// TinyTapeout user-pin bundle: enable, count stream, control and status pins.
interface power_check_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/power_check_core.sv
// Input register, HUNT/ACQ/LOCK tracker, saturating error/loss counters and
// capture of the last bad sample.
module power_check_core
  import power_check_pkg::*;
#(
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        ui_in,
  input  logic              chk_en,
  input  logic              clr,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [LOSS_W-1:0] loss_cnt,
  output logic [7:0]        bad_q
);

  localparam int RUN_W  = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
  localparam int MISS_W = (LOSS_N > 1) ? $clog2(LOSS_N) : 1;
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_N - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_N - 1);

  state_e              state_q, state_d;
  logic [7:0]          d_q, exp_q;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [ERR_W-1:0]    err_d;
  logic [LOSS_W-1:0]   loss_d;
  logic [7:0]          bad_d;
  logic                match, err_hit, loss_hit, acq_done;

  // Every state reloads the expectation from the sample just compared, so
  // exp is simply the previous sample plus one.
  assign match    = (d_q == exp_q);
  assign err_hit  = (state_q == LOCK) && !match;
  assign loss_hit = err_hit && (miss_q == MISS_LAST);
  assign acq_done = (state_q == ACQ) && match && (run_q == RUN_LAST);

  // NOTE: sequential state uses non-blocking (<=) so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state_q <= HUNT;
    else if (ena) state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT:    state_d = ACQ;
      ACQ:     if (acq_done) state_d = LOCK;
      LOCK:    if (loss_hit) state_d = HUNT;
      default: state_d = HUNT;
    endcase
    if (!chk_en) state_d = HUNT;
  end

  always_comb begin
    locked = (state_q == LOCK);
  end

  always_comb begin
    run_d  = '0;
    miss_d = '0;
    if (state_q == ACQ && match && !acq_done) run_d = run_q + RUN_W'(1);
    if (err_hit && !loss_hit)                 miss_d = miss_q + MISS_W'(1);

    err_d  = err_cnt;
    loss_d = loss_cnt;
    bad_d  = bad_q;
    if (err_hit) begin
      bad_d = d_q;
      if (err_cnt != '1) err_d = err_cnt + ERR_W'(1);
    end
    if (loss_hit && loss_cnt != '1) loss_d = loss_cnt + LOSS_W'(1);
    // Clearing takes priority over a same-cycle increment.
    if (clr) begin
      err_d  = '0;
      loss_d = '0;
      bad_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q       <= '0;
      exp_q     <= '0;
      run_q     <= '0;
      miss_q    <= '0;
      err_cnt   <= '0;
      loss_cnt  <= '0;
      bad_q     <= '0;
      err_pulse <= 1'b0;
    end else if (ena) begin
      d_q       <= ui_in;
      exp_q     <= d_q + 8'd1;
      run_q     <= run_d;
      miss_q    <= miss_d;
      err_cnt   <= err_d;
      loss_cnt  <= loss_d;
      bad_q     <= bad_d;
      err_pulse <= err_hit;
    end
  end

endmodule

// File: rtl/tt_um_power_check.sv
// Top level: reset synchronizer, heartbeat, result mux and TinyTapeout pin map.
module tt_um_power_check
  import power_check_pkg::*;
#(
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 4
) (
  input logic          clk,
  input logic          rst_n,
  power_check_if.slave bus
);

  logic [1:0]        rst_sync;
  logic              rst_n_sync;
  logic [HB_W-1:0]   hb_q;
  logic              locked, err_pulse, err_sat;
  logic [ERR_W-1:0]  err_cnt;
  logic [LOSS_W-1:0] loss_cnt;
  logic [7:0]        bad_q;
  logic [7:0]        uo_mux;
  logic [1:0]        sel;
  logic              unused_uio;

  // Asserts immediately with rst_n, releases two clocks later on clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_sync = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync)  hb_q <= '0;
    else if (bus.ena) hb_q <= hb_q + HB_W'(1);
  end

  power_check_core #(
    .LOCK_N (LOCK_N),
    .LOSS_N (LOSS_N)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n_sync),
    .ena       (bus.ena),
    .ui_in     (bus.ui_in),
    .chk_en    (bus.uio_in[0]),
    .clr       (bus.uio_in[1]),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .loss_cnt  (loss_cnt),
    .bad_q     (bad_q)
  );

  assign sel     = bus.uio_in[3:2];
  assign err_sat = (err_cnt == '1);

  always_comb begin
    uo_mux = '0;
    unique case (sel)
      SEL_ERR_LO: uo_mux = err_cnt[7:0];
      SEL_ERR_HI: uo_mux = err_cnt[15:8];
      SEL_BAD:    uo_mux = bad_q;
      SEL_LOSS:   uo_mux = loss_cnt;
      default:    uo_mux = '0;
    endcase
  end

  assign bus.uo_out  = uo_mux;
  assign bus.uio_out = {hb_q[HB_W-1], err_sat, err_pulse, locked, 4'b0000};
  assign bus.uio_oe  = UIO_OE_VAL;

  assign unused_uio = &{1'b0, bus.uio_in[7:4]};

endmodule

// File: tb/tb_tt_um_power_check.sv
// Randomized bench for tt_um_power_check against a behavioural model of the
// increment checker; a second instance with a huge LOSS_N reaches saturation.
module tb_tt_um_power_check;

  localparam int LOCK_N     = 4;
  localparam int LOSS_N     = 4;
  localparam int LOSS_N_SAT = 1 << 20;
  localparam int M_HUNT = 0, M_ACQ = 1, M_LOCK = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  power_check_if bus ();
  power_check_if bus_s ();
  assign bus_s.ena    = bus.ena;
  assign bus_s.ui_in  = bus.ui_in;
  assign bus_s.uio_in = bus.uio_in;

  tt_um_power_check #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus)
  );
  tt_um_power_check #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N_SAT)) dut_s (
    .clk (clk), .rst_n (rst_n), .bus (bus_s)
  );

  typedef struct {
    int mode;
    int d;
    int expect_v;
    int run;
    int miss;
    int err;
    int loss;
    int bad;
    int hb;
    bit pulse;
  } mdl_t;

  mdl_t m, ms;
  int   rel;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   chk_v, clr_v;
  logic [1:0] sel_v;
  logic [7:0] last;
  int   pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t s;
    s.mode = M_HUNT; s.d = 0; s.expect_v = 0; s.run = 0; s.miss = 0;
    s.err = 0; s.loss = 0; s.bad = 0; s.hb = 0; s.pulse = 1'b0;
    return s;
  endfunction

  // One enabled clock of the checker, straight from the stream rules.
  function automatic mdl_t mdl_step(mdl_t s, int loss_n, int ui, bit chk, bit clr);
    mdl_t n = s;
    bit   ok = (s.d == s.expect_v);
    n.pulse    = 1'b0;
    n.expect_v = (s.d + 1) % 256;
    case (s.mode)
      M_HUNT: begin n.run = 0; n.miss = 0; n.mode = M_ACQ; end
      M_ACQ: begin
        if (ok) begin
          n.run = s.run + 1;
          if (n.run == LOCK_N) begin n.mode = M_LOCK; n.run = 0; n.miss = 0; end
        end else n.run = 0;
      end
      default: begin
        if (ok) n.miss = 0;
        else begin
          n.err   = (s.err < 65535) ? s.err + 1 : 65535;
          n.bad   = s.d;
          n.pulse = 1'b1;
          n.miss  = s.miss + 1;
          if (n.miss == loss_n) begin
            n.loss = (s.loss < 255) ? s.loss + 1 : 255;
            n.mode = M_HUNT;
            n.miss = 0;
          end
        end
      end
    endcase
    if (!chk) n.mode = M_HUNT;
    if (clr) begin n.err = 0; n.loss = 0; n.bad = 0; end
    n.d  = ui;
    n.hb = (s.hb + 1) % (1 << 24);
    return n;
  endfunction

  function automatic logic [23:0] mdl_pins(mdl_t s, logic [1:0] sel);
    logic [7:0] uo;
    logic [7:0] st;
    case (sel)
      2'b00:   uo = 8'(s.err % 256);
      2'b01:   uo = 8'(s.err / 256);
      2'b10:   uo = 8'(s.bad);
      default: uo = 8'(s.loss);
    endcase
    st = {((s.hb >> 23) & 1) != 0, s.err == 65535, s.pulse, s.mode == M_LOCK, 4'b0000};
    return {8'hF0, st, uo};
  endfunction

  task automatic drive(input logic [7:0] ui);
    bus.ui_in  = ui;
    bus.uio_in = {4'($urandom_range(0, 15)), sel_v, clr_v, chk_v};
  endtask

  task automatic tick(input bit cmp);
    @(posedge clk);
    if (!rst_n) begin
      m = mdl_reset(); ms = mdl_reset(); rel = 0;
    end else if (rel < 2) begin
      rel++;
    end else if (bus.ena) begin
      m  = mdl_step(m,  LOSS_N,     int'(bus.ui_in), bus.uio_in[0], bus.uio_in[1]);
      ms = mdl_step(ms, LOSS_N_SAT, int'(bus.ui_in), bus.uio_in[0], bus.uio_in[1]);
    end
    #1;
    pulses += int'(bus.uio_out[5]);
    if (cmp) begin
      check("pins", {8'h00, bus.uio_oe, bus.uio_out, bus.uo_out},
            {8'h00, mdl_pins(m, bus.uio_in[3:2])});
      check("pins_sat", {8'h00, bus_s.uio_oe, bus_s.uio_out, bus_s.uo_out},
            {8'h00, mdl_pins(ms, bus.uio_in[3:2])});
    end
  endtask

  task automatic feed(input logic [7:0] ui, input bit cmp);
    drive(ui);
    last = ui;
    tick(cmp);
  endtask

  task automatic read_sel(input logic [1:0] s, input bit sat, output logic [7:0] v);
    sel_v = s;
    bus.uio_in[3:2] = s;
    #1;
    v = sat ? bus_s.uo_out : bus.uo_out;
  endtask

  logic [7:0] v, r, b;
  logic [7:0] snap_uo [4];
  logic [7:0] snap_uio;
  int lock_edge;

  initial begin
    bus.ena = 1'b1; chk_v = 1'b0; clr_v = 1'b0; sel_v = 2'b00; pulses = 0;
    m = mdl_reset(); ms = mdl_reset(); rel = 0;
    drive(8'h00);
    rst_n = 1'b0;
    repeat (3) tick(1'b1);
    for (int s = 0; s < 4; s++) begin
      read_sel(2'(s), 1'b0, v);
      check("rst_uo", {24'h0, v}, 32'h0);
    end
    check("rst_uio_out", {24'h0, bus.uio_out}, 32'h0);
    check("rst_uio_oe", {24'h0, bus.uio_oe}, 32'hF0);

    // Release reset and let the synchronizer settle.
    @(negedge clk);
    rst_n = 1'b1;
    chk_v = 1'b1; sel_v = 2'b00;
    drive(8'h00);
    tick(1'b1); tick(1'b1);

    // Incrementing stream from 0x00: lock on edge 2 + LOCK_N.
    lock_edge = 0;
    b = 8'h00;
    for (int k = 1; k <= 9; k++) begin
      feed(b, 1'b1);
      b = b + 8'd1;
      if (bus.uio_out[4] && lock_edge == 0) lock_edge = k;
    end
    check("lock_edge", lock_edge, 2 + LOCK_N);
    read_sel(2'b00, 1'b0, v);
    check("err_after_lock", {24'h0, v}, 32'h0);

    // One glitch while locked.
    while (b != 8'h10) begin feed(b, 1'b1); b = b + 8'd1; end
    pulses = 0;
    feed(8'h10, 1'b1); feed(8'h11, 1'b1); feed(8'h55, 1'b1);
    feed(8'h56, 1'b1); feed(8'h57, 1'b1); feed(8'h58, 1'b1);
    check("err_pulse_width", pulses, 1);
    read_sel(2'b10, 1'b0, v);
    check("bad_q", {24'h0, v}, 32'h55);
    read_sel(2'b00, 1'b0, v);
    check("err_one", {24'h0, v}, 32'h1);
    check("still_locked", {31'h0, bus.uio_out[4]}, 32'h1);

    // Increment across the 0xFF -> 0x00 wrap.
    b = 8'h59;
    while (b != 8'hFD) begin feed(b, 1'b1); b = b + 8'd1; end
    for (int k = 0; k < 8; k++) begin feed(b, 1'b1); b = b + 8'd1; end
    read_sel(2'b00, 1'b0, v);
    check("wrap_no_err", {24'h0, v}, 32'h1);
    check("wrap_locked", {31'h0, bus.uio_out[4]}, 32'h1);

    // Clear counters, then four random non-incrementing bytes force loss.
    clr_v = 1'b1; feed(last + 8'd1, 1'b1); clr_v = 1'b0;
    read_sel(2'b00, 1'b0, v);
    check("clr_err", {24'h0, v}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      do r = 8'($urandom_range(0, 255)); while (r == last + 8'd1);
      feed(r, 1'b1);
    end
    feed(last + 8'd1, 1'b1);
    check("loss_unlocked", {31'h0, bus.uio_out[4]}, 32'h0);
    read_sel(2'b11, 1'b0, v);
    check("loss_cnt", {24'h0, v}, 32'h1);
    read_sel(2'b00, 1'b0, v);
    check("err_four", {24'h0, v}, 32'h4);
    sel_v = 2'b00;
    for (int k = 0; k < 5; k++) feed(last + 8'd1, 1'b1);
    check("relocked", {31'h0, bus.uio_out[4]}, 32'h1);

    // Saturate the error counter on the instance that never drops lock.
    clr_v = 1'b1; feed(last + 8'd1, 1'b1); clr_v = 1'b0;
    for (int k = 0; k < 65534; k++) feed(last + 8'd2, 1'b0);
    feed(last + 8'd1, 1'b1);
    read_sel(2'b00, 1'b1, v);
    check("sat_pre_lo", {24'h0, v}, 32'hFE);
    read_sel(2'b01, 1'b1, v);
    check("sat_pre_hi", {24'h0, v}, 32'hFF);
    check("sat_pre_flag", {31'h0, bus_s.uio_out[6]}, 32'h0);
    for (int k = 0; k < 3; k++) feed(last + 8'd2, 1'b1);
    feed(last + 8'd1, 1'b1);
    read_sel(2'b00, 1'b1, v);
    check("sat_lo", {24'h0, v}, 32'hFF);
    read_sel(2'b01, 1'b1, v);
    check("sat_hi", {24'h0, v}, 32'hFF);
    check("sat_flag", {31'h0, bus_s.uio_out[6]}, 32'h1);

    // Clear coincident with a counted error.
    feed(last + 8'd2, 1'b1);
    clr_v = 1'b1; feed(last + 8'd1, 1'b1); clr_v = 1'b0;
    for (int s = 0; s < 4; s++) begin
      read_sel(2'(s), 1'b1, v);
      check("clr_sat_uo", {24'h0, v}, 32'h0);
    end
    check("clr_sat_flag", {31'h0, bus_s.uio_out[6]}, 32'h0);
    read_sel(2'b11, 1'b0, v);
    check("clr_loss", {24'h0, v}, 32'h0);

    // Relock, take one error, then freeze with ena low under garbage.
    sel_v = 2'b00;
    for (int k = 0; k < 8; k++) feed(last + 8'd1, 1'b1);
    feed(last + 8'd7, 1'b1);
    feed(last + 8'd1, 1'b1);
    for (int s = 0; s < 4; s++) read_sel(2'(s), 1'b0, snap_uo[s]);
    snap_uio = bus.uio_out;
    bus.ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk_v = 1'($urandom_range(0, 1));
      clr_v = 1'($urandom_range(0, 1));
      feed(8'($urandom_range(0, 255)), 1'b1);
      check("ena_oe", {24'h0, bus.uio_oe}, 32'hF0);
    end
    for (int s = 0; s < 4; s++) begin
      read_sel(2'(s), 1'b0, v);
      check("ena_hold_uo", {24'h0, v}, {24'h0, snap_uo[s]});
    end
    check("ena_hold_uio", {24'h0, bus.uio_out}, {24'h0, snap_uio});
    bus.ena = 1'b1; chk_v = 1'b1; clr_v = 1'b0; sel_v = 2'b00;
    for (int k = 0; k < 4; k++) feed(last + 8'd1, 1'b1);

    // Asynchronous reset in mid-operation.
    #2;
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 4; s++) begin
      read_sel(2'(s), 1'b0, v);
      check("midrst_uo", {24'h0, v}, 32'h0);
      read_sel(2'(s), 1'b1, v);
      check("midrst_uo_sat", {24'h0, v}, 32'h0);
    end
    check("midrst_uio", {24'h0, bus.uio_out}, 32'h0);
    check("midrst_oe", {24'h0, bus.uio_oe}, 32'hF0);
    tick(1'b1); tick(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
